// File: rtl/x_muldiv.sv
// x_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
//
// Runs MULT/MULTU/DIV/DIVU one radix-2 step per cycle: shift-add for multiply,
// restoring division for divide. Both work on operand magnitudes, and the sign
// is fixed up at the end. MTHI/MTLO write HI/LO in a single cycle.
//
// Optional feature macro: MULDIV_FAST_MULT_EN. When it is defined, MULT/MULTU
// complete at the accepting edge using a full-width multiplier. DIV/DIVU are
// unaffected.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        asynchronous reset, active low
//   start      request valid; accepted only while busy=0
//   op         0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   rs_d       operand A / dividend / MTHI-MTLO source
//   rt_d       operand B / divisor
//   kill       abandon the in-flight operation (pipeline flush)
//   hi, lo     architectural HI/LO registers
//   busy       operation in flight; HI/LO not yet valid
//   done       one-cycle pulse after HI/LO are written by a mul/div
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 FIX), for observation only
//
// Handshake: a request is taken at a rising edge when start=1, busy=0 and
// kill=0. There is no backpressure beyond busy. A start seen while busy=1,
// or together with kill, is dropped without any effect.
module x_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_d,
  input  logic [WIDTH-1:0] rt_d,
  input  logic             kill,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST_MULT = 1'b1;
`else
  localparam bit FAST_MULT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    hi_q, lo_q;
  logic                busy_q, done_q;
  logic                is_div_q;   // current op is a divide
  logic                neg_q;      // product / quotient sign
  logic                neg_rem_q;  // remainder sign (sign of dividend)
  logic                div0_q;     // divisor was zero when sampled
  logic [WIDTH-1:0]    opa_q;      // original dividend bits, for divide by zero
  logic [WIDTH-1:0]    mcand_q;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]  acc_q;      // mult: {partial hi, multiplier}; div: {rem, quo}

  // Decode and operand magnitudes for the request being sampled
  logic             op_is_mul, op_is_div, op_signed, a_neg, b_neg, launch;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

  always_comb begin
    op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed && rs_d[WIDTH-1];
    b_neg     = op_signed && rt_d[WIDTH-1];
    a_mag     = a_neg ? -rs_d : rs_d;
    b_mag     = b_neg ? -rt_d : rt_d;
    // Sign- or zero-extended full-width product is correct for both flavours
    ext_a     = {{WIDTH{a_neg ? 1'b1 : 1'b0}}, rs_d};
    ext_b     = {{WIDTH{b_neg ? 1'b1 : 1'b0}}, rt_d};
    fast_prod = ext_a * ext_b;
    launch    = start && !kill && (op_is_div || (op_is_mul && !FAST_MULT));
  end

  // One iteration step, and the final sign fix-up
  logic [WIDTH-1:0]   mul_addend, quo_raw, rem_raw, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

  always_comb begin
    mul_addend = acc_q[0] ? mcand_q : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring step: bring in the next dividend bit, subtract if it fits
    div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff   = div_shift - {1'b0, mcand_q};
    div_next   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    prod_fix   = neg_q ? -acc_q : acc_q;
    quo_raw    = acc_q[WIDTH-1:0];
    rem_raw    = acc_q[2*WIDTH-1:WIDTH];
    quo_fix    = neg_q ? -quo_raw : quo_raw;
    rem_fix    = neg_rem_q ? -rem_raw : rem_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opa_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= op_is_div;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= op_is_div && (rt_d == '0);
            opa_q     <= rs_d;
            mcand_q   <= op_is_div ? b_mag : a_mag;
            acc_q     <= {{WIDTH{1'b0}}, (op_is_div ? a_mag : b_mag)};
          end else if (start && !kill) begin
            if (op == OP_MTHI) hi_q <= rs_d;
            if (op == OP_MTLO) lo_q <= rs_d;
            if (op_is_mul && FAST_MULT) begin
              hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
              lo_q   <= fast_prod[WIDTH-1:0];
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!kill) begin
            done_q <= 1'b1;
            if (!is_div_q) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (div0_q) begin
              hi_q <= opa_q;
              lo_q <= {WIDTH{1'b1}};
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_x_muldiv.sv
// Testbench for x_muldiv: directed vectors, scoreboard queue of expected
// {HI,LO} values, popped by a monitor whenever done pulses.
module tb_x_muldiv;

  localparam int W = 32;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, kill;
  logic [2:0]   op;
  logic [W-1:0] rs_d, rt_d;
  logic [W-1:0] hi, lo;
  logic         busy, done;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  x_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .op        (op),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .kill      (kill),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        mon_exp = exp_q.pop_front();
        chk("hilo_result", {hi, lo}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the request is taken at the following posedge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    rs_d  = a;
    rt_d  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Counts busy cycles until busy drops; returns at the negedge of the done cycle
  task automatic wait_done(input string name, input int exp_busy);
    int c;
    c = 0;
    @(negedge clk);
    while (busy === 1'b1 && c < 100) begin
      c++;
      @(negedge clk);
    end
    chk(name, 64'(c), 64'(exp_busy));
  endtask

  task automatic drop_check();
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int exp_busy);
    exp_q.push_back({eh, el});
    issue(o, a, b);
    wait_done(name, exp_busy);
    drop_check();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] lo_before;
  logic [2:0]   kill_op;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'd0;
    rs_d  = '0;
    rt_d  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_neg_busy", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_BUSY);

    // Back-to-back: second start on the done cycle
    exp_q.push_back({32'd2, 32'd14});
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu_busy", DIV_BUSY);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_b2b_busy", DIV_BUSY);
    drop_check();

    run_op("div0_busy", OP_DIV, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, DIV_BUSY);
    run_op("div_ovf_busy", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DIV_BUSY);
    run_op("mult_mixed_busy", OP_MULT, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, MUL_BUSY);
    run_op("divu_big_busy", OP_DIVU, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, DIV_BUSY);
    run_op("div_negdiv_busy", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, DIV_BUSY);
    run_op("multu_pow_busy", OP_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, MUL_BUSY);
    run_op("multu_max_busy", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, MUL_BUSY);

    // MTHI / MTLO while idle
    issue(OP_MTHI, 32'hA5A5A5A5, 32'd0);
    @(negedge clk);
    chk("mthi_value", 64'(hi), 64'(32'hA5A5A5A5));
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(OP_MTLO, 32'h5A5A5A5A, 32'd0);
    @(negedge clk);
    chk("mtlo_value", 64'(lo), 64'(32'h5A5A5A5A));

    // MTLO issued while busy is dropped
    lo_before = lo;
    exp_q.push_back({32'd0, 32'd3});
    issue(OP_DIVU, 32'd12, 32'd4);
    @(negedge clk);
    issue(OP_MTLO, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    chk("mtlo_busy_ignored", 64'(lo), 64'(lo_before));
    chk("mtlo_busy_still_busy", 64'(busy), 64'd1);
    wait_done("divu_after_mtlo_busy", DIV_BUSY - 2);
    drop_check();

    // Kill mid-run: HI/LO keep prior values, no done
    issue(OP_MTHI, 32'h11111111, 32'd0);
    @(negedge clk);
    issue(OP_MTLO, 32'h22222222, 32'd0);
    @(negedge clk);
    kill_op = (MUL_BUSY == 0) ? OP_DIVU : OP_MULTU;
    issue(kill_op, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_hilo", {hi, lo}, {32'h11111111, 32'h22222222});
    repeat (40) @(negedge clk);

    // kill together with start in IDLE: start dropped
    kill = 1'b1;
    issue(OP_MTHI, 32'h99999999, 32'd0);
    kill = 1'b0;
    @(negedge clk);
    chk("kill_start_idle", 64'(hi), 64'(32'h11111111));

    // Reset mid-run clears everything at once
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_after_busy", 64'(busy), 64'd0);

    run_op("mult_after_rst_busy", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, MUL_BUSY);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
